// File: rtl/uart_pkg.sv
// Shared UART constants: launch FSM encoding and default buffer geometry.
// Reused by the transmit and receive side buffers.
package uart_pkg;

    localparam int DWIDTH_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty/count and a sticky overflow flag.
// Pushes into a full FIFO are dropped; pops from an empty FIFO are ignored.
module uart_sync_fifo #(
    parameter int  DWIDTH = 8,
    parameter int  DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    input  logic              pop_i,
    input  logic              clr_overflow_i,
    output logic [DWIDTH-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       count_o,
    output logic              overflow_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [AW:0]       count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;
    logic              push;
    logic              pop;

    assign push = wr_en_i & ~full_q;
    assign pop  = pop_i & ~empty_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + ONE;
        else if (!push && pop) count_d = count_q - ONE;
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
        // A dropped push outranks a clear landing on the same edge.
        overflow_d = (wr_en_i & full_q) | (overflow_q & ~clr_overflow_i);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    assign rd_data_o  = mem_q[rptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of uart_tx: queues host bytes and launches them
// one per frame over the data_valid/busy handshake.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int  DWIDTH = DWIDTH_DEF,
    parameter int  DEPTH  = DEPTH_DEF,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count,
    output logic              overflow,
    input  logic              clr_overflow,
    output logic [DWIDTH-1:0] p_data,
    output logic              data_valid,
    input  logic              busy
);

    logic [1:0]        state_q, state_d;
    logic [DWIDTH-1:0] p_data_q, p_data_d;
    logic              dv_q, dv_d;
    logic              launch;
    logic [DWIDTH-1:0] rd_data;

    uart_sync_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .wr_en_i        (wr_en),
        .wr_data_i      (wr_data),
        .pop_i          (launch),
        .clr_overflow_i (clr_overflow),
        .rd_data_o      (rd_data),
        .full_o         (full),
        .empty_o        (empty),
        .count_o        (count),
        .overflow_o     (overflow)
    );

    assign launch = (state_q == ST_IDLE) & ~empty & ~busy;

    always_comb begin
        state_d  = state_q;
        p_data_d = p_data_q;
        dv_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    p_data_d = rd_data;
                    dv_d     = 1'b1;
                    state_d  = ST_ARM;
                end
            end
            ST_ARM:  if (busy)  state_d = ST_SEND;
            ST_SEND: if (!busy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            p_data_q <= '0;
            dv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_data_q <= p_data_d;
            dv_q     <= dv_d;
        end
    end

    assign p_data     = p_data_q;
    assign data_valid = dv_q;

endmodule
